traceback_reader: RTL and testbench

- Read-side consumer of the alignment traceback memory that the scoring grid fills.
- Each memory word is one visited cell: x in [CORD_LENGTH-1:0], y in [2*CORD_LENGTH-1:CORD_LENGTH]. Address 0 holds the end cell; the last written word holds (0,0).
- The block walks the memory from address 0 and classifies every step as diagonal, up or left.
- It emits one aligned column per cell (s1 char or gap, s2 char or gap) over a valid/ready stream, in end-to-start order.

---
 rtl/traceback_reader.sv | 254 +++++++++++++++++++++++++
 tb/tb_traceback_reader.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/traceback_reader.sv
// traceback_reader: walks the traceback memory from address 0 and streams one aligned column
// per visited cell. Define TRACEBACK_SCORE_EN to add a running alignment score output.
module traceback_reader #(
    parameter int unsigned LENGTH      = 10,
    parameter int unsigned CWIDTH      = 2,
    parameter int unsigned CORD_LENGTH = 8,
    parameter int unsigned MEM_SIZE    = 9,
    parameter int unsigned BYTE_SIZE   = 2 * CORD_LENGTH,
    parameter int unsigned SWIDTH      = 16,
    parameter int          MATCH       = 1,
    parameter int          MISMATCH    = -1,
    parameter int          INDEL       = -1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [LENGTH*CWIDTH-1:0] s1,
    input  logic [LENGTH*CWIDTH-1:0] s2,
    output logic                     ren,
    output logic [MEM_SIZE-1:0]      raddr,
    input  logic [BYTE_SIZE-1:0]     rdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CWIDTH-1:0]        out_c1,
    output logic [CWIDTH-1:0]        out_c2,
    output logic                     out_gap1,
    output logic                     out_gap2,
    output logic                     out_last,
`ifdef TRACEBACK_SCORE_EN
    output logic signed [SWIDTH-1:0] score,
`endif
    output logic                     busy,
    output logic                     done,
    output logic                     error
);

    localparam int unsigned CntW = $clog2(2 * LENGTH + 1);

    typedef enum logic [3:0] {
        StIdle, StRdCur, StLdCur, StRdNxt, StLdNxt, StEmit, StEmitLast, StDone, StErr
    } state_e;

    typedef struct packed {
        logic [CWIDTH-1:0] c1;
        logic [CWIDTH-1:0] c2;
        logic              gap1;
        logic              gap2;
        logic              last;
    } col_t;

    state_e                 state_q, state_d;
    logic [MEM_SIZE-1:0]    raddr_q, raddr_d;
    logic                   ren_q, ren_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [CORD_LENGTH-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
    logic [CORD_LENGTH-1:0] nxt_x_q, nxt_x_d, nxt_y_q, nxt_y_d;
    logic                   out_valid_q, out_valid_d;
    col_t                   col_q, col_d;
    logic                   busy_q, busy_d, done_q, done_d, error_q, error_d;

    logic [CORD_LENGTH-1:0] rd_x, rd_y;
    logic                   hs;
    logic                   step_x, step_y, hold_x, hold_y;

    function automatic logic [CWIDTH-1:0] char_at(input logic [LENGTH*CWIDTH-1:0] str,
                                                  input logic [CORD_LENGTH-1:0]   idx);
        logic [CWIDTH-1:0] c;
        c = '0;
        for (int i = 0; i < int'(LENGTH); i++) begin
            if (idx == CORD_LENGTH'(i)) c = str[i*CWIDTH +: CWIDTH];
        end
        return c;
    endfunction

    assign rd_x = rdata[CORD_LENGTH-1:0];
    assign rd_y = rdata[2*CORD_LENGTH-1:CORD_LENGTH];
    assign hs   = out_valid_q && out_ready;

    // Step classification of the freshly read cell against the current cell.
    assign step_x = ({1'b0, cur_x_q} == ({1'b0, rd_x} + (CORD_LENGTH + 1)'(1)));
    assign step_y = ({1'b0, cur_y_q} == ({1'b0, rd_y} + (CORD_LENGTH + 1)'(1)));
    assign hold_x = (rd_x == cur_x_q);
    assign hold_y = (rd_y == cur_y_q);

`ifdef TRACEBACK_SCORE_EN
    logic signed [SWIDTH-1:0] score_q, score_d;
    logic signed [SWIDTH-1:0] delta;

    always_comb begin
        if (col_q.gap1 || col_q.gap2) delta = SWIDTH'(INDEL);
        else if (col_q.c1 == col_q.c2) delta = SWIDTH'(MATCH);
        else delta = SWIDTH'(MISMATCH);
    end
`endif

    always_comb begin
        state_d     = state_q;
        raddr_d     = raddr_q;
        ren_d       = 1'b0;
        cnt_d       = cnt_q;
        cur_x_d     = cur_x_q;
        cur_y_d     = cur_y_q;
        nxt_x_d     = nxt_x_q;
        nxt_y_d     = nxt_y_q;
        out_valid_d = out_valid_q;
        col_d       = col_q;
`ifdef TRACEBACK_SCORE_EN
        score_d     = score_q;
        if (hs) score_d = score_q + delta;
`endif

        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (start) begin
                    raddr_d = '0;
                    ren_d   = 1'b1;
                    cnt_d   = CntW'(1);
                    state_d = StRdCur;
`ifdef TRACEBACK_SCORE_EN
                    score_d = '0;
`endif
                end
            end
            StRdCur: state_d = StLdCur;
            StLdCur: begin
                cur_x_d = rd_x;
                cur_y_d = rd_y;
                if (rd_x >= CORD_LENGTH'(LENGTH) || rd_y >= CORD_LENGTH'(LENGTH)) begin
                    state_d = StErr;
                end else if (rd_x == '0 && rd_y == '0) begin
                    col_d       = '{c1: char_at(s1, '0), c2: char_at(s2, '0),
                                    gap1: 1'b0, gap2: 1'b0, last: 1'b1};
                    out_valid_d = 1'b1;
                    state_d     = StEmitLast;
                end else begin
                    raddr_d = raddr_q + MEM_SIZE'(1);
                    ren_d   = 1'b1;
                    state_d = StRdNxt;
                end
            end
            StRdNxt: state_d = StLdNxt;
            StLdNxt: begin
                nxt_x_d = rd_x;
                nxt_y_d = rd_y;
                if (step_x && step_y) begin
                    col_d = '{c1: char_at(s1, cur_y_q), c2: char_at(s2, cur_x_q),
                              gap1: 1'b0, gap2: 1'b0, last: 1'b0};
                    out_valid_d = 1'b1;
                    state_d     = StEmit;
                end else if (hold_x && step_y) begin
                    col_d = '{c1: char_at(s1, cur_y_q), c2: '0,
                              gap1: 1'b0, gap2: 1'b1, last: 1'b0};
                    out_valid_d = 1'b1;
                    state_d     = StEmit;
                end else if (step_x && hold_y) begin
                    col_d = '{c1: '0, c2: char_at(s2, cur_x_q),
                              gap1: 1'b1, gap2: 1'b0, last: 1'b0};
                    out_valid_d = 1'b1;
                    state_d     = StEmit;
                end else begin
                    state_d = StErr;
                end
            end
            StEmit: begin
                if (hs) begin
                    cur_x_d     = nxt_x_q;
                    cur_y_d     = nxt_y_q;
                    col_d       = '0;
                    out_valid_d = 1'b0;
                    if (nxt_x_q == '0 && nxt_y_q == '0) begin
                        col_d       = '{c1: char_at(s1, '0), c2: char_at(s2, '0),
                                        gap1: 1'b0, gap2: 1'b0, last: 1'b1};
                        out_valid_d = 1'b1;
                        state_d     = StEmitLast;
                    end else if (cnt_q == CntW'(2 * LENGTH - 1)) begin
                        // Longer than any monotone path through the grid.
                        state_d = StErr;
                    end else begin
                        cnt_d   = cnt_q + CntW'(1);
                        raddr_d = raddr_q + MEM_SIZE'(1);
                        ren_d   = 1'b1;
                        state_d = StRdNxt;
                    end
                end
            end
            StEmitLast: begin
                if (hs) begin
                    col_d       = '0;
                    out_valid_d = 1'b0;
                    state_d     = StDone;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d  = !(state_d inside {StIdle, StDone, StErr});
        done_d  = (state_d == StDone);
        error_d = (state_d == StErr);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            raddr_q     <= '0;
            ren_q       <= 1'b0;
            cnt_q       <= '0;
            cur_x_q     <= '0;
            cur_y_q     <= '0;
            nxt_x_q     <= '0;
            nxt_y_q     <= '0;
            out_valid_q <= 1'b0;
            col_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
`ifdef TRACEBACK_SCORE_EN
            score_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            raddr_q     <= raddr_d;
            ren_q       <= ren_d;
            cnt_q       <= cnt_d;
            cur_x_q     <= cur_x_d;
            cur_y_q     <= cur_y_d;
            nxt_x_q     <= nxt_x_d;
            nxt_y_q     <= nxt_y_d;
            out_valid_q <= out_valid_d;
            col_q       <= col_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
`ifdef TRACEBACK_SCORE_EN
            score_q     <= score_d;
`endif
        end
    end

    assign ren       = ren_q;
    assign raddr     = raddr_q;
    assign out_valid = out_valid_q;
    assign out_c1    = col_q.c1;
    assign out_c2    = col_q.c2;
    assign out_gap1  = col_q.gap1;
    assign out_gap2  = col_q.gap2;
    assign out_last  = col_q.last;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
`ifdef TRACEBACK_SCORE_EN
    assign score     = score_q;
`endif

endmodule

// File: tb/tb_traceback_reader.sv
// Directed bench for traceback_reader with LENGTH=4; checks the score when TRACEBACK_SCORE_EN.
module tb_traceback_reader;

    localparam int unsigned LENGTH = 4;
    localparam int unsigned CWIDTH = 2;
    localparam int unsigned CORD   = 8;
    localparam int unsigned MEMW   = 9;
    localparam int unsigned BW     = 2 * CORD;
    localparam int unsigned SW     = 16;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     start;
    logic [LENGTH*CWIDTH-1:0] s1;
    logic [LENGTH*CWIDTH-1:0] s2;
    logic                     ren;
    logic [MEMW-1:0]          raddr;
    logic [BW-1:0]            rdata;
    logic                     out_valid;
    logic                     out_ready;
    logic [CWIDTH-1:0]        out_c1;
    logic [CWIDTH-1:0]        out_c2;
    logic                     out_gap1;
    logic                     out_gap2;
    logic                     out_last;
    logic                     busy;
    logic                     done;
    logic                     error;
`ifdef TRACEBACK_SCORE_EN
    logic signed [SW-1:0]     score;
`endif

    traceback_reader #(
        .LENGTH(LENGTH), .CWIDTH(CWIDTH), .CORD_LENGTH(CORD), .MEM_SIZE(MEMW),
        .BYTE_SIZE(BW), .SWIDTH(SW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .s1(s1), .s2(s2),
        .ren(ren), .raddr(raddr), .rdata(rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_c1(out_c1), .out_c2(out_c2), .out_gap1(out_gap1), .out_gap2(out_gap2),
        .out_last(out_last),
`ifdef TRACEBACK_SCORE_EN
        .score(score),
`endif
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    logic [BW-1:0] mem [0:(1<<MEMW)-1];
    always @(posedge clk) if (ren) rdata <= mem[raddr];

    int   ren_cnt  = 0;
    int   ren_bad  = 0;
    logic ren_prev = 1'b0;
    always @(negedge clk) begin
        if (ren) ren_cnt++;
        if (ren && (ren_prev || out_valid)) ren_bad++;
        ren_prev = ren;
    end

    typedef struct {
        logic [CORD-1:0]   x;
        logic [CORD-1:0]   y;
        logic [CWIDTH-1:0] c1;
        logic [CWIDTH-1:0] c2;
        logic              g1;
        logic              g2;
        logic              last;
    } vec_t;

    vec_t tab [8];
    int   tab_n;
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input int x, input int y, input int c1, input int c2,
                                input int g1, input int g2, input int last);
        vec_t v;
        v.x    = CORD'(x);
        v.y    = CORD'(y);
        v.c1   = CWIDTH'(c1);
        v.c2   = CWIDTH'(c2);
        v.g1   = (g1 != 0);
        v.g2   = (g2 != 0);
        v.last = (last != 0);
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic load_mem();
        for (int i = 0; i < tab_n; i++) mem[i] = {tab[i].y, tab[i].x};
        mem[tab_n] = {CORD'(7), CORD'(7)};
    endtask

    // s1 = s2 = 0x1B: char 0 = 3, 1 = 2, 2 = 1, 3 = 0.
    task automatic load_diag();
        tab[0] = mk(3, 3, 0, 0, 0, 0, 0);
        tab[1] = mk(2, 2, 1, 1, 0, 0, 0);
        tab[2] = mk(1, 1, 2, 2, 0, 0, 0);
        tab[3] = mk(0, 0, 3, 3, 0, 0, 1);
        tab_n  = 4;
        load_mem();
    endtask

    task automatic run_walk(input string tag, input bit toggle, input bit poke,
                            input bit exp_err, input int exp_reads, input int exp_score);
        int idx;
        int cyc;
        int r0;
        int act;
        int exp;
        r0 = ren_cnt;
        out_ready = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        idx = 0;
        cyc = 0;
        while (cyc < 200 && !done && !error) begin
            out_ready = toggle ? ((cyc % 2) == 1) : 1'b1;
            start     = poke && (cyc == 6);
            #1;
            if (out_valid) begin
                if (idx < tab_n) begin
                    act = int'({out_c1, out_c2, out_gap1, out_gap2, out_last});
                    exp = int'({tab[idx].c1, tab[idx].c2, tab[idx].g1, tab[idx].g2,
                                tab[idx].last});
                    check($sformatf("%s_column%0d", tag, idx), act, exp);
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL %s_extra_column: got column %0d, expected only %0d",
                             tag, idx, tab_n);
                end
                if (out_ready) idx++;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({tag, "_timeout"}, int'(cyc < 200), 1);
        check({tag, "_columns"}, idx, tab_n);
        check({tag, "_done"}, int'(done), int'(!exp_err));
        check({tag, "_error"}, int'(error), int'(exp_err));
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_valid_idle"}, int'(out_valid), 0);
        check({tag, "_reads"}, ren_cnt - r0, exp_reads);
`ifdef TRACEBACK_SCORE_EN
        check({tag, "_score"}, int'(score), exp_score);
`else
        if (exp_score != exp_score + 1) begin end
`endif
    endtask

    initial begin
        int hs;
        int cyc;
        s1        = 8'h1B;
        s2        = 8'h1B;
        start     = 1'b0;
        out_ready = 1'b0;
        reset     = 1'b1;
        #1;
        check("reset_ren", int'(ren), 0);
        check("reset_raddr", int'(raddr), 0);
        check("reset_outs", int'({out_valid, out_c1, out_c2, out_gap1, out_gap2, out_last}), 0);
        check("reset_status", int'({busy, done, error}), 0);
`ifdef TRACEBACK_SCORE_EN
        check("reset_score", int'(score), 0);
`endif
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        load_diag();
        run_walk("diag", 1'b0, 1'b0, 1'b0, 4, 4);

        // left, diag (mismatch), up, diag (match), last.
        tab[0] = mk(3, 3, 0, 0, 1, 0, 0);
        tab[1] = mk(2, 3, 0, 1, 0, 0, 0);
        tab[2] = mk(1, 2, 1, 0, 0, 1, 0);
        tab[3] = mk(1, 1, 2, 2, 0, 0, 0);
        tab[4] = mk(0, 0, 3, 3, 0, 0, 1);
        tab_n  = 5;
        load_mem();
        run_walk("mixed", 1'b0, 1'b0, 1'b0, 5, -1);

        load_diag();
        run_walk("toggle", 1'b1, 1'b1, 1'b0, 4, 4);

        mem[0] = {CORD'(3), CORD'(3)};
        mem[1] = {CORD'(3), CORD'(3)};
        mem[2] = {CORD'(7), CORD'(7)};
        tab_n  = 0;
        run_walk("nomove", 1'b0, 1'b0, 1'b1, 2, 0);

        load_diag();
        run_walk("restart", 1'b0, 1'b0, 1'b0, 4, 4);

        mem[0] = {CORD'(0), CORD'(5)};
        tab_n  = 0;
        run_walk("range", 1'b0, 1'b0, 1'b1, 1, 0);

        // Abort with the third column pending; out_valid must drop without a clock edge.
        load_diag();
        out_ready = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        hs  = 0;
        cyc = 0;
        while (hs < 2 && cyc < 100) begin
            #1;
            if (out_valid && out_ready) hs++;
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        while (!out_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("abort_reach_third", int'(out_valid && cyc < 100), 1);
        #2;
        reset = 1'b1;
        #1;
        check("abort_valid", int'(out_valid), 0);
        check("abort_status", int'({busy, done, error, ren}), 0);
        check("abort_raddr", int'(raddr), 0);
        @(negedge clk);
        reset = 1'b0;

        tab[0] = mk(0, 0, 3, 3, 0, 0, 1);
        tab_n  = 1;
        load_mem();
        run_walk("single", 1'b0, 1'b0, 1'b0, 1, 1);

        check("ren_pulse_rules", ren_bad, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
